// File: rtl/jit_couple_n.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : jit_couple_n                                                 |
// | Description : Couples NIN selectable operand channels (direct or cascade   |
// |               source) to an accelerator through per-channel 2-entry skid   |
// |               buffers, and eagerly forks the accelerator result stream to  |
// |               a direct and a cascade sink. Configuration is double-        |
// |               buffered and only switches once the block has drained.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
// Ports
//   ACLK, ARESET                      clock, synchronous active-high reset
//   sIn_*   [NIN]/[NIN*DW]            direct source streams (slave)
//   scIn_*  [NIN]/[NIN*DW]            cascade source streams (slave)
//   mAccOut_* [NIN]/[NIN*DW]          accelerator operand streams (master)
//   sAccInC_* [1]/[DW]                accelerator result stream (slave)
//   mOutC_*   [1]/[DW]                direct result sink (master)
//   mcOutC_*  [1]/[DW]                cascade result sink (master)
//   CONF [2*NIN+2]                    {mask[1:0], sel[NIN-1], ..., sel[0]}
//   CONF_LD                           load request for CONF
//   BUSY                              data in flight (buffers or fork flags)
module jit_couple_n #(
  parameter int DW  = 32,
  parameter int NIN = 2
) (
  input  logic              ACLK,
  input  logic              ARESET,

  input  logic [NIN-1:0]    sIn_tvalid,
  output logic [NIN-1:0]    sIn_tready,
  input  logic [NIN*DW-1:0] sIn_tdata,

  input  logic [NIN-1:0]    scIn_tvalid,
  output logic [NIN-1:0]    scIn_tready,
  input  logic [NIN*DW-1:0] scIn_tdata,

  output logic [NIN-1:0]    mAccOut_tvalid,
  input  logic [NIN-1:0]    mAccOut_tready,
  output logic [NIN*DW-1:0] mAccOut_tdata,

  input  logic              sAccInC_tvalid,
  output logic              sAccInC_tready,
  input  logic [DW-1:0]     sAccInC_tdata,

  output logic              mOutC_tvalid,
  input  logic              mOutC_tready,
  output logic [DW-1:0]     mOutC_tdata,

  output logic              mcOutC_tvalid,
  input  logic              mcOutC_tready,
  output logic [DW-1:0]     mcOutC_tdata,

  input  logic [2*NIN+1:0]  CONF,
  input  logic              CONF_LD,
  output logic              BUSY
);

  localparam int CW = 2 * NIN + 2;

  // Configuration: active and pending copies.
  logic [CW-1:0]     cfg_q;
  logic [CW-1:0]     cfg_nxt;
  logic [CW-1:0]     pend_cfg_q;
  logic              pend_q;
  logic              pend_nxt;

  // Per-channel skid buffers, packed per channel.
  logic [2*NIN-1:0]  cnt_q;
  logic [2*NIN-1:0]  cnt_nxt;
  logic [NIN*DW-1:0] mem0_q;       // head entry, drives mAccOut_tdata
  logic [NIN*DW-1:0] mem1_q;       // second entry
  logic [NIN*DW-1:0] mem0_nxt;
  logic [NIN*DW-1:0] mem1_nxt;
  logic [NIN-1:0]    sin_rdy_q;
  logic [NIN-1:0]    scin_rdy_q;
  logic [NIN-1:0]    sin_rdy_nxt;
  logic [NIN-1:0]    scin_rdy_nxt;

  // Result fork.
  logic [1:0]        done_q;
  logic [1:0]        done_nxt;
  logic [1:0]        mask;
  logic [1:0]        sink_valid;
  logic [1:0]        sink_ready;
  logic              acc_ready;
  logic              acc_hs;

  assign BUSY = (|cnt_q) | (|done_q);

  // A pending configuration is promoted on the first idle cycle. A CONF_LD in
  // that same cycle becomes the next pending value behind it.
  assign cfg_nxt  = (pend_q && !BUSY) ? pend_cfg_q : cfg_q;
  assign pend_nxt = CONF_LD | (pend_q & BUSY);

  for (genvar i = 0; i < NIN; i++) begin : g_ch
    logic [1:0]    cnt;
    logic          push;
    logic          pop;
    logic [DW-1:0] din;
    logic [1:0]    sel_n;
    logic [1:0]    cnt_n;
    logic [DW-1:0] head_n;
    logic [DW-1:0] tail_n;

    assign cnt   = cnt_q[2*i +: 2];
    // At most one of the two readys is ever set, so it also selects the data.
    assign push  = (sin_rdy_q[i] & sIn_tvalid[i]) | (scin_rdy_q[i] & scIn_tvalid[i]);
    assign din   = sin_rdy_q[i] ? sIn_tdata[i*DW +: DW] : scIn_tdata[i*DW +: DW];
    assign pop   = (cnt != 2'd0) & mAccOut_tready[i];
    assign sel_n = cfg_nxt[2*i +: 2];

    // Pop shifts the tail into the head first; a push then lands in the first
    // free slot, which gives the 1-cycle pass-through when the buffer is empty.
    always_comb begin
      cnt_n  = cnt;
      head_n = mem0_q[i*DW +: DW];
      tail_n = mem1_q[i*DW +: DW];
      if (pop) begin
        head_n = tail_n;
        cnt_n  = cnt_n - 2'd1;
      end
      if (push) begin
        if (cnt_n == 2'd0) begin
          head_n = din;
        end else begin
          tail_n = din;
        end
        cnt_n = cnt_n + 2'd1;
      end
    end

    assign cnt_nxt[2*i +: 2]    = cnt_n;
    assign mem0_nxt[i*DW +: DW] = head_n;
    assign mem1_nxt[i*DW +: DW] = tail_n;

    // Registered readys look at the post-update occupancy, so a ready seen
    // high always has a free slot behind it.
    assign sin_rdy_nxt[i]  = (cnt_n != 2'd2) & ~pend_nxt & (sel_n == 2'd1);
    assign scin_rdy_nxt[i] = (cnt_n != 2'd2) & ~pend_nxt & (sel_n == 2'd2);

    assign mAccOut_tvalid[i] = (cnt != 2'd0);
  end

  assign sIn_tready    = sin_rdy_q;
  assign scIn_tready   = scin_rdy_q;
  assign mAccOut_tdata = mem0_q;

  // Eager fork: each enabled sink takes the word as soon as it can; done[k]
  // remembers a sink that already has it until the source word retires.
  assign mask       = cfg_q[2*NIN +: 2];
  assign sink_ready = {mcOutC_tready, mOutC_tready};
  assign sink_valid = {2{sAccInC_tvalid}} & mask & ~done_q;
  assign acc_ready  = &(done_q | sink_ready | ~mask);
  assign acc_hs     = sAccInC_tvalid & acc_ready;
  assign done_nxt   = acc_hs ? 2'b00 : (done_q | (sink_valid & sink_ready));

  assign sAccInC_tready = acc_ready;
  assign mOutC_tvalid   = sink_valid[0];
  assign mcOutC_tvalid  = sink_valid[1];
  assign mOutC_tdata    = sAccInC_tdata;
  assign mcOutC_tdata   = sAccInC_tdata;

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      cfg_q      <= '0;
      pend_cfg_q <= '0;
      pend_q     <= 1'b0;
      cnt_q      <= '0;
      mem0_q     <= '0;
      mem1_q     <= '0;
      sin_rdy_q  <= '0;
      scin_rdy_q <= '0;
      done_q     <= 2'b00;
    end else begin
      cfg_q      <= cfg_nxt;
      pend_q     <= pend_nxt;
      if (CONF_LD) begin
        pend_cfg_q <= CONF;
      end
      cnt_q      <= cnt_nxt;
      mem0_q     <= mem0_nxt;
      mem1_q     <= mem1_nxt;
      sin_rdy_q  <= sin_rdy_nxt;
      scin_rdy_q <= scin_rdy_nxt;
      done_q     <= done_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_jit_couple_n.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_jit_couple_n                                              |
// | Description : Self-checking bench for jit_couple_n (DW=32, NIN=2).         |
// |               Scoreboard queues per operand channel and per result sink.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_jit_couple_n;

  localparam int DW  = 32;
  localparam int NIN = 2;

  logic              ACLK = 1'b0;
  logic              ARESET;
  logic [NIN-1:0]    sIn_tvalid,  sIn_tready;
  logic [NIN*DW-1:0] sIn_tdata;
  logic [NIN-1:0]    scIn_tvalid, scIn_tready;
  logic [NIN*DW-1:0] scIn_tdata;
  logic [NIN-1:0]    mAccOut_tvalid, mAccOut_tready;
  logic [NIN*DW-1:0] mAccOut_tdata;
  logic              sAccInC_tvalid, sAccInC_tready;
  logic [DW-1:0]     sAccInC_tdata;
  logic              mOutC_tvalid, mOutC_tready;
  logic [DW-1:0]     mOutC_tdata;
  logic              mcOutC_tvalid, mcOutC_tready;
  logic [DW-1:0]     mcOutC_tdata;
  logic [2*NIN+1:0]  CONF;
  logic              CONF_LD;
  logic              BUSY;

  int n_checks = 0;
  int n_fail   = 0;

  // Scoreboard: 0/1 = operand channels, 2 = mOutC, 3 = mcOutC.
  logic [DW-1:0] q_acc0[$];
  logic [DW-1:0] q_acc1[$];
  logic [DW-1:0] q_mo[$];
  logic [DW-1:0] q_mco[$];

  jit_couple_n #(.DW(DW), .NIN(NIN)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .sIn_tvalid(sIn_tvalid), .sIn_tready(sIn_tready), .sIn_tdata(sIn_tdata),
    .scIn_tvalid(scIn_tvalid), .scIn_tready(scIn_tready), .scIn_tdata(scIn_tdata),
    .mAccOut_tvalid(mAccOut_tvalid), .mAccOut_tready(mAccOut_tready), .mAccOut_tdata(mAccOut_tdata),
    .sAccInC_tvalid(sAccInC_tvalid), .sAccInC_tready(sAccInC_tready), .sAccInC_tdata(sAccInC_tdata),
    .mOutC_tvalid(mOutC_tvalid), .mOutC_tready(mOutC_tready), .mOutC_tdata(mOutC_tdata),
    .mcOutC_tvalid(mcOutC_tvalid), .mcOutC_tready(mcOutC_tready), .mcOutC_tdata(mcOutC_tdata),
    .CONF(CONF), .CONF_LD(CONF_LD), .BUSY(BUSY)
  );

  always #5 ACLK = ~ACLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic void sb_push(int id, logic [DW-1:0] d);
    case (id)
      0: q_acc0.push_back(d);
      1: q_acc1.push_back(d);
      2: q_mo.push_back(d);
      default: q_mco.push_back(d);
    endcase
  endfunction

  function automatic int sb_size(int id);
    case (id)
      0: return q_acc0.size();
      1: return q_acc1.size();
      2: return q_mo.size();
      default: return q_mco.size();
    endcase
  endfunction

  // An empty queue yields X so an unexpected extra word cannot compare equal.
  function automatic logic [DW-1:0] sb_pop(int id);
    if (sb_size(id) == 0) return 'x;
    case (id)
      0: return q_acc0.pop_front();
      1: return q_acc1.pop_front();
      2: return q_mo.pop_front();
      default: return q_mco.pop_front();
    endcase
  endfunction

  function automatic void sb_clear();
    q_acc0.delete(); q_acc1.delete(); q_mo.delete(); q_mco.delete();
  endfunction

  // Drive point: 1 time unit after the rising edge.
  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic load_cfg(input logic [2*NIN+1:0] v);
    logic idle;
    idle    = 1'b0;
    CONF    = v;
    CONF_LD = 1'b1;
    tick();
    CONF_LD = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge ACLK);
      idle = !BUSY;
      tick();
      if (idle) break;
    end
    n_checks++;
    if (!idle) begin
      n_fail++;
      $display("FAIL load_cfg_idle: BUSY stayed %b, required 0 within 50 cycles", BUSY);
    end
  endtask

  task automatic test_reset();
    ARESET = 1'b1;
    tick(); tick();
    ARESET = 1'b0;
    @(negedge ACLK);
    n_checks++; if (sIn_tready !== 2'b00) begin n_fail++; $display("FAIL reset_sIn_tready: got %b want 00", sIn_tready); end
    n_checks++; if (scIn_tready !== 2'b00) begin n_fail++; $display("FAIL reset_scIn_tready: got %b want 00", scIn_tready); end
    n_checks++; if (mAccOut_tvalid !== 2'b00) begin n_fail++; $display("FAIL reset_mAccOut_tvalid: got %b want 00", mAccOut_tvalid); end
    n_checks++; if (mOutC_tvalid !== 1'b0) begin n_fail++; $display("FAIL reset_mOutC_tvalid: got %b want 0", mOutC_tvalid); end
    n_checks++; if (mcOutC_tvalid !== 1'b0) begin n_fail++; $display("FAIL reset_mcOutC_tvalid: got %b want 0", mcOutC_tvalid); end
    n_checks++; if (BUSY !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", BUSY); end
    n_checks++; if (sAccInC_tready !== 1'b1) begin n_fail++; $display("FAIL reset_sAccInC_tready: got %b want 1", sAccInC_tready); end
    n_checks++; if (mAccOut_tdata !== '0) begin n_fail++; $display("FAIL reset_mAccOut_tdata: got %h want 0", mAccOut_tdata); end
    tick();
  endtask

  // ch0 = direct, ch1 = cascade; unselected sources carry garbage.
  task automatic test_stream();
    int k0, k1, got0, got1, first0, last0, first1, last1;
    logic acc0_prev, acc1_prev;
    logic [DW-1:0] w0_prev, w1_prev, exp;
    k0 = 0; k1 = 0; got0 = 0; got1 = 0; first0 = 0; last0 = 0; first1 = 0; last1 = 0;
    acc0_prev = 1'b0; acc1_prev = 1'b0; w0_prev = '0; w1_prev = '0;
    load_cfg(6'h09);
    CONF = 6'h3F;            // no load pulse: must not take effect
    mAccOut_tready = 2'b11;
    for (int c = 0; c < 80; c++) begin
      sIn_tvalid[0]        = (k0 < 16);
      sIn_tdata[31:0]      = 32'(k0 + 1);
      scIn_tvalid[1]       = (k1 < 16);
      scIn_tdata[63:32]    = 32'(k1 + 1);
      sIn_tvalid[1]        = 1'b1;
      sIn_tdata[63:32]     = 32'hDEAD_0000 + 32'(c);
      scIn_tvalid[0]       = 1'b1;
      scIn_tdata[31:0]     = 32'hBEEF_0000 + 32'(c);
      @(negedge ACLK);
      if (acc0_prev) begin
        n_checks++;
        if (mAccOut_tvalid[0] !== 1'b1 || mAccOut_tdata[31:0] !== w0_prev) begin
          n_fail++; $display("FAIL stream_latency0: got v=%b d=%h want v=1 d=%h", mAccOut_tvalid[0], mAccOut_tdata[31:0], w0_prev);
        end
      end
      if (acc1_prev) begin
        n_checks++;
        if (mAccOut_tvalid[1] !== 1'b1 || mAccOut_tdata[63:32] !== w1_prev) begin
          n_fail++; $display("FAIL stream_latency1: got v=%b d=%h want v=1 d=%h", mAccOut_tvalid[1], mAccOut_tdata[63:32], w1_prev);
        end
      end
      if (mAccOut_tvalid[0] === 1'b1) begin
        exp = sb_pop(0); got0++;
        n_checks++;
        if (mAccOut_tdata[31:0] !== exp) begin n_fail++; $display("FAIL stream_order0: got %h want %h", mAccOut_tdata[31:0], exp); end
      end
      if (mAccOut_tvalid[1] === 1'b1) begin
        exp = sb_pop(1); got1++;
        n_checks++;
        if (mAccOut_tdata[63:32] !== exp) begin n_fail++; $display("FAIL stream_order1: got %h want %h", mAccOut_tdata[63:32], exp); end
      end
      n_checks++;
      if ({sIn_tready[1], scIn_tready[0]} !== 2'b00) begin
        n_fail++; $display("FAIL stream_unselected_ready: got %b want 00", {sIn_tready[1], scIn_tready[0]});
      end
      acc0_prev = sIn_tvalid[0] && sIn_tready[0];
      acc1_prev = scIn_tvalid[1] && scIn_tready[1];
      if (acc0_prev) begin
        w0_prev = sIn_tdata[31:0]; sb_push(0, w0_prev);
        if (k0 == 0) first0 = c;
        last0 = c; k0++;
      end
      if (acc1_prev) begin
        w1_prev = scIn_tdata[63:32]; sb_push(1, w1_prev);
        if (k1 == 0) first1 = c;
        last1 = c; k1++;
      end
      tick();
      if (got0 == 16 && got1 == 16) break;
    end
    sIn_tvalid = 2'b00; scIn_tvalid = 2'b00;
    n_checks++; if (got0 != 16 || got1 != 16) begin n_fail++; $display("FAIL stream_count: got %0d/%0d want 16/16", got0, got1); end
    n_checks++; if (last0 - first0 != 15) begin n_fail++; $display("FAIL stream_gapless0: span %0d want 15", last0 - first0); end
    n_checks++; if (last1 - first1 != 15) begin n_fail++; $display("FAIL stream_gapless1: span %0d want 15", last1 - first1); end
  endtask

  task automatic test_backpressure();
    int k0, got0, hold_left;
    logic hold_started;
    logic [DW-1:0] exp;
    k0 = 0; got0 = 0; hold_left = 0; hold_started = 1'b0;
    mAccOut_tready = 2'b11;
    for (int c = 0; c < 100; c++) begin
      if (!hold_started && k0 >= 5) begin hold_left = 5; hold_started = 1'b1; end
      mAccOut_tready[0] = (hold_left == 0);
      sIn_tvalid[0]     = (k0 < 16);
      sIn_tdata[31:0]   = 32'h0000_0100 + 32'(k0);
      @(negedge ACLK);
      if (mAccOut_tvalid[0] && mAccOut_tready[0]) begin
        exp = sb_pop(0); got0++;
        n_checks++;
        if (mAccOut_tdata[31:0] !== exp) begin n_fail++; $display("FAIL bp_data: got %h want %h", mAccOut_tdata[31:0], exp); end
      end
      if (hold_left == 1) begin
        n_checks++; if (sb_size(0) != 2) begin n_fail++; $display("FAIL bp_buffered: got %0d words want 2", sb_size(0)); end
        n_checks++; if (sIn_tready[0] !== 1'b0) begin n_fail++; $display("FAIL bp_ready_low: got %b want 0", sIn_tready[0]); end
        n_checks++; if (mAccOut_tvalid[0] !== 1'b1) begin n_fail++; $display("FAIL bp_valid_held: got %b want 1", mAccOut_tvalid[0]); end
      end
      if (sIn_tvalid[0] && sIn_tready[0]) begin sb_push(0, sIn_tdata[31:0]); k0++; end
      if (hold_left > 0) hold_left--;
      tick();
      if (got0 == 16) break;
    end
    sIn_tvalid = 2'b00;
    n_checks++; if (got0 != 16 || sb_size(0) != 0) begin n_fail++; $display("FAIL bp_complete: got %0d left %0d want 16 left 0", got0, sb_size(0)); end
  endtask

  task automatic test_fork();
    int dm, dmc;
    logic hs;
    logic [DW-1:0] exp;
    dm = 0; dmc = 0;
    load_cfg(6'h39);
    mOutC_tready   = 1'b1;
    mcOutC_tready  = 1'b0;
    sAccInC_tdata  = 32'hA5A5_A5A5;
    sAccInC_tvalid = 1'b1;
    sb_push(2, sAccInC_tdata); sb_push(3, sAccInC_tdata);
    for (int c = 0; c < 6; c++) begin
      if (c == 3) mcOutC_tready = 1'b1;
      @(negedge ACLK);
      if (mOutC_tvalid && mOutC_tready) begin
        exp = sb_pop(2); dm++;
        n_checks++; if (mOutC_tdata !== exp) begin n_fail++; $display("FAIL fork_mo_data: got %h want %h", mOutC_tdata, exp); end
      end
      if (mcOutC_tvalid && mcOutC_tready) begin
        exp = sb_pop(3); dmc++;
        n_checks++; if (mcOutC_tdata !== exp) begin n_fail++; $display("FAIL fork_mco_data: got %h want %h", mcOutC_tdata, exp); end
      end
      if (c <= 2) begin
        n_checks++; if (sAccInC_tready !== 1'b0) begin n_fail++; $display("FAIL fork_stall c%0d: got %b want 0", c, sAccInC_tready); end
      end
      if (c == 1) begin
        n_checks++; if (mOutC_tvalid !== 1'b0 || BUSY !== 1'b1) begin n_fail++; $display("FAIL fork_done0: got v=%b busy=%b want v=0 busy=1", mOutC_tvalid, BUSY); end
      end
      if (c == 3) begin
        n_checks++; if (sAccInC_tready !== 1'b1 || mcOutC_tvalid !== 1'b1) begin n_fail++; $display("FAIL fork_release: got rdy=%b mcv=%b want 1 1", sAccInC_tready, mcOutC_tvalid); end
      end
      if (c == 5) begin
        n_checks++; if (BUSY !== 1'b0) begin n_fail++; $display("FAIL fork_flags_clear: got busy=%b want 0", BUSY); end
      end
      hs = sAccInC_tvalid && sAccInC_tready;
      tick();
      if (hs) sAccInC_tvalid = 1'b0;
    end
    n_checks++; if (dm != 1 || dmc != 1) begin n_fail++; $display("FAIL fork_once: got mo=%0d mco=%0d want 1 1", dm, dmc); end
  endtask

  task automatic test_fork_random();
    int sent, dm, dmc;
    logic hs;
    logic [DW-1:0] exp;
    sent = 0; dm = 0; dmc = 0;
    sAccInC_tvalid = 1'b1;
    sAccInC_tdata  = 32'h7000_0000;
    sb_push(2, sAccInC_tdata); sb_push(3, sAccInC_tdata);
    for (int c = 0; c < 300; c++) begin
      mOutC_tready  = 1'($urandom_range(0, 1));
      mcOutC_tready = 1'($urandom_range(0, 1));
      @(negedge ACLK);
      if (mOutC_tvalid && mOutC_tready) begin
        exp = sb_pop(2); dm++;
        n_checks++; if (mOutC_tdata !== exp) begin n_fail++; $display("FAIL forkr_mo: got %h want %h", mOutC_tdata, exp); end
      end
      if (mcOutC_tvalid && mcOutC_tready) begin
        exp = sb_pop(3); dmc++;
        n_checks++; if (mcOutC_tdata !== exp) begin n_fail++; $display("FAIL forkr_mco: got %h want %h", mcOutC_tdata, exp); end
      end
      hs = sAccInC_tvalid && sAccInC_tready;
      tick();
      if (hs) begin
        sent++;
        if (sent < 8) begin
          sAccInC_tdata = 32'h7000_0000 + 32'(sent);
          sb_push(2, sAccInC_tdata); sb_push(3, sAccInC_tdata);
        end else begin
          sAccInC_tvalid = 1'b0;
        end
      end
      if (sent == 8) break;
    end
    sAccInC_tvalid = 1'b0;
    n_checks++;
    if (sent != 8 || dm != 8 || dmc != 8 || sb_size(2) != 0 || sb_size(3) != 0) begin
      n_fail++; $display("FAIL forkr_totals: got sent=%0d mo=%0d mco=%0d want 8 8 8", sent, dm, dmc);
    end
  endtask

  task automatic test_mask00();
    int hs_n;
    hs_n = 0;
    load_cfg(6'h09);
    mOutC_tready  = 1'b1;
    mcOutC_tready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      sAccInC_tvalid = 1'b1;
      sAccInC_tdata  = 32'h0000_1000 + 32'(c);
      @(negedge ACLK);
      n_checks++; if (sAccInC_tready !== 1'b1) begin n_fail++; $display("FAIL mask00_ready c%0d: got %b want 1", c, sAccInC_tready); end
      n_checks++; if ({mcOutC_tvalid, mOutC_tvalid} !== 2'b00) begin n_fail++; $display("FAIL mask00_valids c%0d: got %b want 00", c, {mcOutC_tvalid, mOutC_tvalid}); end
      if (sAccInC_tready === 1'b1) hs_n++;
      tick();
    end
    sAccInC_tvalid = 1'b0;
    n_checks++; if (hs_n != 4) begin n_fail++; $display("FAIL mask00_rate: got %0d want 4", hs_n); end
  endtask

  // cfg: ch0 direct, ch1 cascade -> ch0 cascade, ch1 direct, loaded with ch0 full.
  task automatic test_reconfig();
    int got0, acc_sc;
    logic full;
    logic [DW-1:0] exp;
    got0 = 0; acc_sc = 0; full = 1'b0;
    mAccOut_tready = 2'b00;
    for (int c = 0; c < 10; c++) begin
      sIn_tvalid[0]   = 1'b1;
      sIn_tdata[31:0] = 32'h0000_0200 + 32'(c);
      @(negedge ACLK);
      if (sIn_tready[0] === 1'b0) full = 1'b1;
      if (sIn_tvalid[0] && sIn_tready[0]) sb_push(0, sIn_tdata[31:0]);
      tick();
      if (full) break;
    end
    n_checks++; if (sb_size(0) != 2) begin n_fail++; $display("FAIL reconf_fill: got %0d words want 2", sb_size(0)); end
    scIn_tvalid[0]   = 1'b1;
    scIn_tdata[31:0] = 32'h0000_05C0;
    CONF             = 6'h06;
    CONF_LD          = 1'b1;
    for (int r = 0; r < 12; r++) begin
      if (r == 1) begin CONF_LD = 1'b0; mAccOut_tready = 2'b11; end
      @(negedge ACLK);
      if (mAccOut_tvalid[0] && mAccOut_tready[0]) begin
        exp = sb_pop(0); got0++;
        n_checks++; if (mAccOut_tdata[31:0] !== exp) begin n_fail++; $display("FAIL reconf_data: got %h want %h", mAccOut_tdata[31:0], exp); end
      end
      if (r == 0) begin
        n_checks++; if (scIn_tready[1] !== 1'b1) begin n_fail++; $display("FAIL reconf_pre_ready: got %b want 1", scIn_tready[1]); end
      end
      if (r >= 1 && r <= 3) begin
        n_checks++; if ({sIn_tready, scIn_tready} !== 4'b0000) begin n_fail++; $display("FAIL reconf_ready_drop r%0d: got %b want 0000", r, {sIn_tready, scIn_tready}); end
      end
      if (r == 2) begin
        n_checks++; if (BUSY !== 1'b1) begin n_fail++; $display("FAIL reconf_busy r2: got %b want 1", BUSY); end
      end
      if (r == 3) begin
        n_checks++; if (BUSY !== 1'b0) begin n_fail++; $display("FAIL reconf_busy r3: got %b want 0", BUSY); end
      end
      if (r == 4) begin
        n_checks++; if ({sIn_tready, scIn_tready} !== 4'b1001) begin n_fail++; $display("FAIL reconf_new_sel: got %b want 1001", {sIn_tready, scIn_tready}); end
      end
      if (sIn_tvalid[0] && sIn_tready[0]) sb_push(0, sIn_tdata[31:0]);
      if (scIn_tvalid[0] && scIn_tready[0]) begin sb_push(0, scIn_tdata[31:0]); acc_sc++; end
      tick();
      if (acc_sc > 0) begin scIn_tvalid[0] = 1'b0; sIn_tvalid[0] = 1'b0; end
      if (acc_sc > 0 && sb_size(0) == 0) break;
    end
    sIn_tvalid = 2'b00; scIn_tvalid = 2'b00;
    n_checks++; if (got0 != 3 || acc_sc != 1) begin n_fail++; $display("FAIL reconf_total: got pop=%0d sc=%0d want 3 1", got0, acc_sc); end
  endtask

  task automatic test_reset_mid();
    logic f0, f1;
    f0 = 1'b0; f1 = 1'b0;
    load_cfg(6'h39);
    mAccOut_tready = 2'b00;
    for (int c = 0; c < 10; c++) begin
      sIn_tvalid[0]     = 1'b1;
      sIn_tdata[31:0]   = 32'h0000_0300 + 32'(c);
      scIn_tvalid[1]    = 1'b1;
      scIn_tdata[63:32] = 32'h0000_0400 + 32'(c);
      @(negedge ACLK);
      f0 = (sIn_tready[0] === 1'b0);
      f1 = (scIn_tready[1] === 1'b0);
      tick();
      if (f0 && f1) break;
    end
    n_checks++; if (mAccOut_tvalid !== 2'b11) begin n_fail++; $display("FAIL rstmid_full: got %b want 11", mAccOut_tvalid); end
    sAccInC_tvalid = 1'b1;
    sAccInC_tdata  = 32'h0000_0BAD;
    mOutC_tready   = 1'b0;
    mcOutC_tready  = 1'b1;
    tick();
    mcOutC_tready  = 1'b0;
    @(negedge ACLK);
    n_checks++;
    if (mcOutC_tvalid !== 1'b0 || mOutC_tvalid !== 1'b1 || sAccInC_tready !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_done1: got mcv=%b mv=%b rdy=%b want 0 1 0", mcOutC_tvalid, mOutC_tvalid, sAccInC_tready);
    end
    tick();
    ARESET         = 1'b1;
    mAccOut_tready = 2'b11;
    mOutC_tready   = 1'b1;
    mcOutC_tready  = 1'b1;
    tick();
    ARESET = 1'b0;
    @(negedge ACLK);
    n_checks++; if (mAccOut_tvalid !== 2'b00) begin n_fail++; $display("FAIL rstmid_accvalid: got %b want 00", mAccOut_tvalid); end
    n_checks++; if ({mcOutC_tvalid, mOutC_tvalid} !== 2'b00) begin n_fail++; $display("FAIL rstmid_sinkvalid: got %b want 00", {mcOutC_tvalid, mOutC_tvalid}); end
    n_checks++; if (BUSY !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b want 0", BUSY); end
    n_checks++; if (sAccInC_tready !== 1'b1) begin n_fail++; $display("FAIL rstmid_accready: got %b want 1", sAccInC_tready); end
    n_checks++; if ({sIn_tready, scIn_tready} !== 4'b0000) begin n_fail++; $display("FAIL rstmid_srcready: got %b want 0000", {sIn_tready, scIn_tready}); end
    tick();
    @(negedge ACLK);
    n_checks++; if ({mAccOut_tvalid, mcOutC_tvalid, mOutC_tvalid} !== 4'b0000) begin n_fail++; $display("FAIL rstmid_after: got %b want 0000", {mAccOut_tvalid, mcOutC_tvalid, mOutC_tvalid}); end
    sIn_tvalid = 2'b00; scIn_tvalid = 2'b00; sAccInC_tvalid = 1'b0;
    sb_clear();
    tick();
  endtask

  initial begin
    ARESET = 1'b1;
    sIn_tvalid = '0; sIn_tdata = '0; scIn_tvalid = '0; scIn_tdata = '0;
    mAccOut_tready = '0; sAccInC_tvalid = 1'b0; sAccInC_tdata = '0;
    mOutC_tready = 1'b0; mcOutC_tready = 1'b0; CONF = '0; CONF_LD = 1'b0;
    #1;
    test_reset();
    test_stream();
    test_backpressure();
    test_fork();
    test_fork_random();
    test_mask00();
    test_reconfig();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/jit_couple_n.md
JIT_COUPLE_N -- requirements
Module: jit_couple_n

Interface
REQ-001 The block SHALL have a parameter DW, default 32: data width of every stream.
REQ-002 The block SHALL have a parameter NIN, default 2, range 1..8: number of accelerator input channels.
REQ-003 The block SHALL have the following ports, listed as name, direction, width and meaning:
- ACLK, in, 1: single clock; all logic on its rising edge.
- ARESET, in, 1: reset; synchronous, active-high.
- sIn_tvalid/sIn_tready/sIn_tdata, in/out/in, NIN/NIN/NIN*DW: direct source streams; channel i occupies bit i and data slice [i*DW +: DW].
- scIn_tvalid/scIn_tready/scIn_tdata, in/out/in, NIN/NIN/NIN*DW: cascade source streams; same packing.
- mAccOut_tvalid/mAccOut_tready/mAccOut_tdata, out/in/out, NIN/NIN/NIN*DW: accelerator operand streams.
- sAccInC_tvalid/sAccInC_tready/sAccInC_tdata, in/out/in, 1/1/DW: accelerator result stream.
- mOutC_tvalid/mOutC_tready/mOutC_tdata, out/in/out, 1/1/DW: direct result sink.
- mcOutC_tvalid/mcOutC_tready/mcOutC_tdata, out/in/out, 1/1/DW: cascade result sink.
- CONF, in, 2*NIN+2: bits [2i+1:2i] select channel i; bits [2*NIN+1:2*NIN] form the output mask.
- CONF_LD, in, 1: one-cycle pulse requesting a load of CONF.
- BUSY, out, 1: data is in flight inside the block.

Function
REQ-004 Channel select SHALL decode as follows: 1 = direct source, 2 = cascade source, 0 or 3 = channel disabled.
REQ-005 Output mask SHALL decode as follows: bit0 enables mOutC, bit1 enables mcOutC.
REQ-006 Each channel SHALL contain a 2-entry skid buffer between the selected source and mAccOut[i].
REQ-007 The source tready of a channel SHALL be registered and asserted only when the buffer holds fewer than 2 entries.
REQ-008 Latency SHALL be 1 cycle: a word accepted at cycle t SHALL appear on mAccOut[i] at cycle t+1.
REQ-009 Sustained throughput SHALL be 1 word per cycle when mAccOut_tready is held high.
REQ-010 Order SHALL be preserved within each channel.
REQ-011 The unselected source of a channel SHALL see tready=0, and its tvalid and tdata SHALL be ignored.
REQ-012 A disabled channel SHALL drive both source treadys to 0; it SHALL still drain any buffered words to mAccOut.
REQ-013 mAccOut_tvalid[i] SHALL be 1 whenever buffer i is non-empty.
REQ-014 The result path SHALL be an eager fork with one registered done flag per sink.
REQ-015 For each sink k: m_k_tvalid = sAccInC_tvalid AND mask[k] AND NOT done[k].
REQ-016 Both result sinks SHALL carry sAccInC_tdata unmodified.
REQ-017 sAccInC_tready SHALL equal the AND, over enabled sinks, of (done[k] OR m_k_tready).
REQ-018 done[k] SHALL be set when sink k handshakes while sAccInC_tready=0.
REQ-019 All done flags SHALL clear on the cycle sAccInC handshakes.
REQ-020 Each result word SHALL be delivered exactly once to every enabled sink, with no duplicates.
REQ-021 With mask=00, sAccInC_tready SHALL be 1 and results SHALL be discarded with both m*_tvalid=0.
REQ-022 BUSY SHALL be 1 if any skid buffer is non-empty or any done flag is set.
REQ-023 Configuration SHALL be held in an active register cfg.
REQ-024 CONF_LD SHALL capture CONF into a pending register and set a pending flag.
REQ-025 A CONF_LD while pending already set SHALL overwrite the pending value.
REQ-026 While pending=1, all source treadys SHALL be forced to 0 so that the block drains.
REQ-027 On the first cycle with pending=1 and BUSY=0, cfg SHALL take the pending value and pending SHALL clear; the new configuration is effective on the following cycle.
REQ-028 CONF_LD asserted while BUSY=0 and pending=0 SHALL make the new configuration effective 2 cycles later.
REQ-029 CONF changes without CONF_LD SHALL have no effect.

Reset
REQ-030 When ARESET=1 at a rising ACLK edge, all buffers SHALL be emptied and all done flags, the pending flag and cfg SHALL be set to 0.
REQ-031 After reset, the following outputs SHALL be 0: sIn_tready, scIn_tready, mAccOut_tvalid, mOutC_tvalid, mcOutC_tvalid and BUSY.
REQ-032 After reset, sAccInC_tready SHALL be 1 (mask=00 discard).
REQ-033 After reset, data outputs SHALL be 0.
REQ-034 Reset asserted mid-transfer SHALL discard all in-flight words, and no partial fork delivery SHALL complete afterwards.

Verification
REQ-035 The bench SHALL cover a select/stream case: NIN=2 with channel0=direct and channel1=cascade; stream 0x1..0x10 on each source with tready always high -> each word appears 1 cycle later, no gaps, in order, and the unselected source tready=0 throughout.
REQ-036 The bench SHALL cover a backpressure case: mAccOut_tready[0] held low for 5 cycles mid-stream -> exactly 2 words are buffered, then sIn_tready[0]=0, and after release no loss or duplication occurs.
REQ-037 The bench SHALL cover a fork case: mask=11, result 0xA5A5A5A5, mOutC_tready=1 and mcOutC_tready=0 for 3 cycles -> mOutC receives exactly one word, done[0]=1, and sAccInC_tready=0 until mcOutC accepts, after which the flags clear.
REQ-038 The bench SHALL cover a reconfiguration-under-load case: CONF_LD while 2 words are buffered -> source readys drop next cycle, buffers drain, cfg updates the cycle after BUSY falls, and the new source is selected after that.
REQ-039 The bench SHALL cover a mask=00 case: 4 results presented -> all consumed at 1 per cycle with both sink tvalids 0.
REQ-040 The bench SHALL cover a reset-mid-operation case: ARESET pulsed for 1 cycle with buffers full and done[1]=1 -> the next cycle shows all tvalids 0, BUSY=0 and sAccInC_tready=1.
